// File: rtl/des_sbox_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : des_sbox_sequencer
// Description : Serialises the eight 6-bit chunks of a DES round word through
//               one shared S-box port and assembles the 32-bit result.
// Revision    : 1.0 - initial release
// ============================================================================
module des_sbox_sequencer #(
    parameter int LOOKUP_LAT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [47:0] in_data,
    output logic [2:0]  sbox_sel,
    output logic [5:0]  sbox_in,
    input  logic [3:0]  sbox_out,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [2:0] c_last_idx = 3'd7;

    state_t      state_q, state_d;
    logic [47:0] word_q, word_d;
    logic [31:0] result_q, result_d;
    logic [2:0]  issue_q, issue_d;
    logic [2:0]  cap_q, cap_d;

    logic [5:0]  w_issue_lsb;
    logic [4:0]  w_cap_lsb;

    // S1 sits in the MSBs of both the word and the result.
    assign w_issue_lsb = 6'd42 - ({3'b000, issue_q} * 6'd6);
    assign w_cap_lsb   = 5'd28 - {cap_q, 2'b00};

    always_comb begin
        state_d   = state_q;
        word_d    = word_q;
        result_d  = result_q;
        issue_d   = issue_q;
        cap_d     = cap_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        sbox_sel  = 3'd0;
        sbox_in   = 6'd0;

        case (state_q)
            IDLE: begin
                in_ready = !rst;
                if (in_valid && in_ready) begin
                    word_d   = in_data;
                    result_d = 32'd0;
                    issue_d  = 3'd0;
                    cap_d    = 3'd0;
                    state_d  = LOOKUP;
                end
            end
            LOOKUP: begin
                sbox_sel = issue_q;
                sbox_in  = word_q[w_issue_lsb +: 6];
                // With a registered bank nothing is returned on the first issue cycle.
                if (LOOKUP_LAT == 0 || issue_q != 3'd0) begin
                    result_d[w_cap_lsb +: 4] = sbox_out;
                    cap_d = cap_q + 3'd1;
                end
                if (issue_q == c_last_idx) begin
                    state_d = (LOOKUP_LAT == 0) ? DONE : DRAIN;
                end else begin
                    issue_d = issue_q + 3'd1;
                end
            end
            DRAIN: begin
                result_d[w_cap_lsb +: 4] = sbox_out;
                state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            word_q   <= 48'd0;
            result_q <= 32'd0;
            issue_q  <= 3'd0;
            cap_q    <= 3'd0;
        end else begin
            state_q  <= state_d;
            word_q   <= word_d;
            result_q <= result_d;
            issue_q  <= issue_d;
            cap_q    <= cap_d;
        end
    end

    assign out_data = result_q;
    assign busy     = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_des_sbox_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_des_sbox_sequencer
// Description : Directed bench for des_sbox_sequencer with golden DES S-boxes,
//               one instance per S-box bank latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_des_sbox_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int sb [512] = '{
        14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,
         0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
         4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0,
        15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13,
        15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,
         3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
         0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15,
        13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9,
        10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8,
        13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
        13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,
         1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12,
         7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15,
        13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
        10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,
         3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14,
         2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9,
        14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
         4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14,
        11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3,
        12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11,
        10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
         9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,
         4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13,
         4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1,
        13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
         1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,
         6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12,
        13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,
         1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
         7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,
         2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11
    };

    function automatic logic [3:0] lut(input logic [2:0] s, input logic [5:0] x);
        int idx;
        idx = int'(s) * 64 + int'({x[5], x[0]}) * 16 + int'(x[4:1]);
        return sb[idx][3:0];
    endfunction

    function automatic logic [31:0] model(input logic [47:0] w);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) r[31-4*i -: 4] = lut(3'(i), w[47-6*i -: 6]);
        return r;
    endfunction

    // Instance 0: combinational bank
    logic        rst0, in_valid0, in_ready0, out_valid0, out_ready0, busy0;
    logic [47:0] in_data0;
    logic [2:0]  sbox_sel0;
    logic [5:0]  sbox_in0;
    logic [3:0]  sbox_out0;
    logic [31:0] out_data0;

    always_comb sbox_out0 = lut(sbox_sel0, sbox_in0);

    des_sbox_sequencer #(.LOOKUP_LAT(0)) dut0 (
        .clk(clk), .rst(rst0), .in_valid(in_valid0), .in_ready(in_ready0),
        .in_data(in_data0), .sbox_sel(sbox_sel0), .sbox_in(sbox_in0),
        .sbox_out(sbox_out0), .out_valid(out_valid0), .out_ready(out_ready0),
        .out_data(out_data0), .busy(busy0)
    );

    // Instance 1: registered bank
    logic        rst1, in_valid1, in_ready1, out_valid1, out_ready1, busy1;
    logic [47:0] in_data1;
    logic [2:0]  sbox_sel1;
    logic [5:0]  sbox_in1;
    logic [3:0]  sbox_out1;
    logic [31:0] out_data1;

    always @(posedge clk) sbox_out1 <= lut(sbox_sel1, sbox_in1);

    des_sbox_sequencer #(.LOOKUP_LAT(1)) dut1 (
        .clk(clk), .rst(rst1), .in_valid(in_valid1), .in_ready(in_ready1),
        .in_data(in_data1), .sbox_sel(sbox_sel1), .sbox_in(sbox_in1),
        .sbox_out(sbox_out1), .out_valid(out_valid1), .out_ready(out_ready1),
        .out_data(out_data1), .busy(busy1)
    );

    int n_total = 0;
    int n_bad   = 0;
    int ticks   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
        ticks++;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run_job0(input logic [47:0] w, output logic [31:0] res, output int lat);
        in_data0   = w;
        in_valid0  = 1'b1;
        out_ready0 = 1'b1;
        chk("job_in_ready", in_ready0, 1);
        tick();
        in_valid0 = 1'b0;
        lat = 1;
        while (!out_valid0 && lat < 40) begin
            tick();
            lat++;
        end
        chk("job_out_valid", out_valid0, 1);
        res = out_data0;
        tick();
    endtask

    initial begin
        logic [31:0] res, expv;
        logic [47:0] a, b;
        int lat, n, acc_t, prev_acc;

        rst0 = 1'b1; in_valid0 = 1'b0; in_data0 = '0; out_ready0 = 1'b0;
        rst1 = 1'b1; in_valid1 = 1'b0; in_data1 = '0; out_ready1 = 1'b0;
        tick();
        tick();
        chk("rst_in_ready_forced", in_ready0, 0);
        chk("rst_out_valid", out_valid0, 0);
        chk("rst_out_data", out_data0, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_sel", sbox_sel0, 0);
        chk("rst_sbox_in", sbox_in0, 0);
        rst0 = 1'b0;
        rst1 = 1'b0;
        #1;
        chk("rst_release_in_ready", in_ready0, 1);

        // All-zeros word
        run_job0(48'h0, res, lat);
        chk("zeros_data", res, 32'hEFA72C4D);
        chk("zeros_latency", lat, 9);
        chk("zeros_idle_busy", busy0, 0);

        // All-ones word with per-cycle port trace
        in_data0 = '1; in_valid0 = 1'b1; out_ready0 = 1'b1;
        chk("ones_idle_sel", sbox_sel0, 0);
        chk("ones_idle_sbox_in", sbox_in0, 0);
        tick();
        in_valid0 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk("ones_sel", sbox_sel0, k);
            chk("ones_sbox_in", sbox_in0, 6'h3F);
            tick();
        end
        chk("ones_out_valid", out_valid0, 1);
        chk("ones_data", out_data0, 32'hD9CE3DCB);
        chk("ones_done_sel", sbox_sel0, 0);
        chk("ones_done_sbox_in", sbox_in0, 0);
        tick();

        // Input stability: ~A during LOOKUP must not leak into the result
        a = 48'h0123_4567_89AB;
        in_data0 = a; in_valid0 = 1'b1; out_ready0 = 1'b1;
        tick();
        in_valid0 = 1'b0;
        in_data0 = ~a;
        n = 0;
        while (!out_valid0 && n < 40) begin tick(); n++; end
        chk("stab_out_valid", out_valid0, 1);
        chk("stab_data", out_data0, model(a));
        tick();

        // Backpressure with a pending word
        a = 48'hA5A5_5A5A_F00F;
        b = 48'h1357_9BDF_2468;
        in_data0 = a; in_valid0 = 1'b1; out_ready0 = 1'b0;
        tick();
        in_data0 = b;
        n = 0;
        while (!out_valid0 && n < 40) begin tick(); n++; end
        chk("bp_out_valid", out_valid0, 1);
        expv = model(a);
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold_data", out_data0, expv);
            chk("bp_hold_valid", out_valid0, 1);
            chk("bp_in_ready_low", in_ready0, 0);
            tick();
        end
        out_ready0 = 1'b1;
        tick();
        chk("bp_in_ready_after", in_ready0, 1);
        tick();
        chk("bp_pending_accepted", busy0, 1);
        in_valid0 = 1'b0;
        n = 0;
        while (!out_valid0 && n < 40) begin tick(); n++; end
        chk("bp_second_data", out_data0, model(b));
        tick();

        // Reset mid-operation
        in_data0 = 48'h1234_5678_9ABC; in_valid0 = 1'b1; out_ready0 = 1'b1;
        tick();
        in_valid0 = 1'b0;
        n = 0;
        while (sbox_sel0 != 3'd3 && n < 20) begin tick(); n++; end
        chk("mid_sel3", sbox_sel0, 3);
        rst0 = 1'b1;
        tick();
        rst0 = 1'b0;
        #1;
        chk("mid_out_valid", out_valid0, 0);
        chk("mid_busy", busy0, 0);
        chk("mid_in_ready", in_ready0, 1);
        chk("mid_out_data", out_data0, 0);
        run_job0(48'h0, res, lat);
        chk("mid_next_job", res, 32'hEFA72C4D);

        // Registered bank: streaming random words
        in_valid1 = 1'b1; out_ready1 = 1'b1;
        prev_acc = 0;
        for (int i = 0; i < 20; i++) begin
            a = {$urandom, $urandom};
            in_data1 = a;
            n = 0;
            while (!in_ready1 && n < 30) begin tick(); n++; end
            chk("lat1_in_ready", in_ready1, 1);
            acc_t = ticks;
            tick();
            lat = 1;
            while (!out_valid1 && lat < 40) begin tick(); lat++; end
            chk("lat1_latency", lat, 10);
            chk("lat1_data", out_data1, model(a));
            if (i > 0) chk("lat1_period", acc_t - prev_acc, 11);
            prev_acc = acc_t;
        end
        in_valid1 = 1'b0;
        tick();
        chk("lat1_final_idle", busy1, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
